cbrt_seq: RTL

Parametrised integer cube-root unit. It computes y = floor(cbrt(a)) and the remainder r = a - y^3 for an unsigned WIDTH-bit operand. It uses a digit-recurrence (one result bit per cycle) and needs no external multiplier. It supersedes the fixed 8-bit binary-search cube root: width is generalised, it adds an explicit start/valid handshake and a remainder output, and latency is fixed. It sits as a datapath slave beside the existing mult-based arithmetic blocks.

---
 rtl/cbrt_pkg.sv | 16 +
 rtl/cbrt_step.sv | 40 ++++
 rtl/cbrt_seq.sv | 89 ++++++++
 3 files changed

// File: rtl/cbrt_pkg.sv
// Shared definitions for the sequential integer cube-root unit.
// The state encoding and the result-width helper are used by cbrt_seq and cbrt_step.
package cbrt_pkg;

    // 2'd3 is never entered; the FSM treats it as IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cbrt_out_w(input int width);
        return (width + 2) / 3;
    endfunction

endpackage

// File: rtl/cbrt_step.sv
// One digit of the cube-root recurrence: try setting the next result bit and
// subtract the matching trial term from the partial remainder if it fits.
module cbrt_step
    import cbrt_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int OUT_W = cbrt_out_w(WIDTH),
    localparam int XW    = 3 * OUT_W + 2,
    localparam int PW    = 2 * OUT_W + 3,
    localparam int KW    = $clog2(OUT_W + 1)
) (
    input  logic [XW-1:0]    x,
    input  logic [OUT_W-1:0] y,
    input  logic [KW-1:0]    k,
    output logic [XW-1:0]    x_next,
    output logic [OUT_W-1:0] y_next
);

    logic [PW-1:0] y2;
    logic [PW-1:0] y2p1;
    logic [PW-1:0] prod;
    logic [PW-1:0] base;
    logic [KW+1:0] shamt;
    logic [XW-1:0] b;
    logic          ge;

    always_comb begin
        y2     = PW'({y, 1'b0});
        y2p1   = y2 + PW'(1);
        prod   = y2 * y2p1;
        // 3*y2*(y2+1) + 1, built from a shift-add so no constant multiply is needed
        base   = (prod << 1) + prod + PW'(1);
        shamt  = {1'b0, k, 1'b0} + {2'b00, k};
        b      = XW'(base) << shamt;
        ge     = (x >= b);
        x_next = ge ? (x - b) : x;
        y_next = y2[OUT_W-1:0] | OUT_W'(ge);
    end

endmodule

// File: rtl/cbrt_seq.sv
// Sequential floor cube root with remainder, one result bit per clock.
// Owns the handshake FSM, the digit counter and the result registers.
//
//  state | meaning
//  IDLE  | waiting for start_i; operand sampled on the accepting edge
//  CALC  | one digit per edge, k = OUT_W-1 down to 0
//  DONE  | results registered, valid_o high for this cycle only
module cbrt_seq
    import cbrt_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int OUT_W = cbrt_out_w(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_bi,
    output logic             busy_o,
    output logic             valid_o,
    output logic [OUT_W-1:0] y_bo,
    output logic [WIDTH-1:0] rem_bo
);

    localparam int XW = 3 * OUT_W + 2;
    localparam int KW = $clog2(OUT_W + 1);

    state_t           state;
    logic [XW-1:0]    x;
    logic [OUT_W-1:0] y;
    logic [KW-1:0]    k;
    logic [XW-1:0]    x_next;
    logic [OUT_W-1:0] y_next;

    cbrt_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .x      (x),
        .y      (y),
        .k      (k),
        .x_next (x_next),
        .y_next (y_next)
    );

    assign busy_o = (state == CALC) || (state == DONE);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= IDLE;
            x       <= '0;
            y       <= '0;
            k       <= '0;
            valid_o <= 1'b0;
            y_bo    <= '0;
            rem_bo  <= '0;
        end else begin
            valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        x     <= XW'(a_bi);
                        y     <= '0;
                        k     <= KW'(OUT_W - 1);
                        state <= CALC;
                    end
                end
                CALC: begin
                    x <= x_next;
                    y <= y_next;
                    if (k == '0) begin
                        // the remainder is bounded by 3y^2+3y, so truncation loses nothing
                        y_bo    <= y_next;
                        rem_bo  <= x_next[WIDTH-1:0];
                        valid_o <= 1'b1;
                        state   <= DONE;
                    end else begin
                        k <= k - KW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
